// File: rtl/charge_pkg.sv
// Shared types and constants for the charge-bay scheduler.
package charge_pkg;

  localparam logic [3:0] MODE_STD  = 4'b0001;
  localparam logic [3:0] MODE_FAST = 4'b0101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic mode_valid(input logic [3:0] mode);
    return (mode == MODE_STD) || (mode == MODE_FAST);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible bay at or after rrPtr, with wrap-around.
module rr_arbiter #(
  parameter int unsigned NUM_BAYS = 4,
  parameter int unsigned IDX_W    = (NUM_BAYS > 1) ? $clog2(NUM_BAYS) : 1
) (
  input  logic [NUM_BAYS-1:0] eligible,
  input  logic [IDX_W-1:0]    rrPtr,
  output logic [NUM_BAYS-1:0] grantOneHot,
  output logic [IDX_W-1:0]    grantIdx
);

  always_comb begin
    int unsigned bay;
    logic        found;
    grantOneHot = '0;
    grantIdx    = '0;
    found       = 1'b0;
    bay         = 0;
    for (int unsigned k = 0; k < NUM_BAYS; k++) begin
      bay = (32'(rrPtr) + k) % NUM_BAYS;
      if (!found && eligible[IDX_W'(bay)]) begin
        found                     = 1'b1;
        grantOneHot[IDX_W'(bay)]  = 1'b1;
        grantIdx                  = IDX_W'(bay);
      end
    end
  end

endmodule

// File: rtl/charge_bay_scheduler.sv
// Shares one down-counting charge timer among NUM_BAYS bays using round-robin arbitration.
module charge_bay_scheduler #(
  parameter int unsigned NUM_BAYS = 4,
  parameter int unsigned TIME_W   = 12
) (
  input  logic                       Clk,
  input  logic                       nReset,
  input  logic                       Tick,
  input  logic [NUM_BAYS-1:0]        Request,
  input  logic [4*NUM_BAYS-1:0]      Mode,
  input  logic [TIME_W*NUM_BAYS-1:0] ChargeTime,
  output logic [NUM_BAYS-1:0]        Grant,
  output logic                       CounterEnable,
  output logic [TIME_W-1:0]          PresentTime,
  output logic                       Done,
  output logic [2:0]                 DoneBay,
  output logic                       Aborted
);
  import charge_pkg::*;

  localparam int unsigned IDX_W = (NUM_BAYS > 1) ? $clog2(NUM_BAYS) : 1;

  logic [3:0]          bayMode [NUM_BAYS];
  logic [TIME_W-1:0]   bayTime [NUM_BAYS];
  logic [NUM_BAYS-1:0] eligible;
  logic [NUM_BAYS-1:0] arbGrant;
  logic [IDX_W-1:0]    arbIdx;

  state_t              state;
  logic [IDX_W-1:0]    rrPtr;
  logic [IDX_W-1:0]    grantIdx;
  logic                fastMode;
  logic [TIME_W-1:0]   tickTime;

  // Unpack per-bay fields and qualify requests by mode.
  always_comb begin
    for (int i = 0; i < int'(NUM_BAYS); i++) begin
      bayMode[i]  = Mode[4*i +: 4];
      bayTime[i]  = ChargeTime[TIME_W*i +: TIME_W];
      eligible[i] = Request[i] && mode_valid(bayMode[i]);
    end
  end

  rr_arbiter #(
    .NUM_BAYS (NUM_BAYS),
    .IDX_W    (IDX_W)
  ) u_arbiter (
    .eligible    (eligible),
    .rrPtr       (rrPtr),
    .grantOneHot (arbGrant),
    .grantIdx    (arbIdx)
  );

  // Fast mode saturates at zero instead of wrapping.
  always_comb begin
    if (fastMode) begin
      tickTime = (PresentTime > TIME_W'(2)) ? PresentTime - TIME_W'(2) : '0;
    end else begin
      tickTime = PresentTime - TIME_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state         <= IDLE;
      Grant         <= '0;
      CounterEnable <= 1'b0;
      PresentTime   <= '0;
      Done          <= 1'b0;
      DoneBay       <= '0;
      Aborted       <= 1'b0;
      rrPtr         <= '0;
      grantIdx      <= '0;
      fastMode      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            grantIdx    <= arbIdx;
            fastMode    <= (bayMode[arbIdx] == MODE_FAST);
            PresentTime <= bayTime[arbIdx];
            if (bayTime[arbIdx] == '0) begin
              state   <= DONE;
              Done    <= 1'b1;
              DoneBay <= 3'(arbIdx);
              Aborted <= 1'b0;
            end else begin
              state         <= CHARGE;
              Grant         <= arbGrant;
              CounterEnable <= 1'b1;
            end
          end
        end
        CHARGE: begin
          // Unplug wins over a coincident tick and freezes the remaining time.
          if (!Request[grantIdx]) begin
            state         <= DONE;
            Grant         <= '0;
            CounterEnable <= 1'b0;
            Done          <= 1'b1;
            DoneBay       <= 3'(grantIdx);
            Aborted       <= 1'b1;
          end else if (Tick) begin
            PresentTime <= tickTime;
            if (tickTime == '0) begin
              state         <= DONE;
              Grant         <= '0;
              CounterEnable <= 1'b0;
              Done          <= 1'b1;
              DoneBay       <= 3'(grantIdx);
              Aborted       <= 1'b0;
            end
          end
        end
        DONE: begin
          rrPtr <= (grantIdx == IDX_W'(NUM_BAYS - 1)) ? '0 : grantIdx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_charge_bay_scheduler.sv
// Self-checking bench for charge_bay_scheduler: directed scenarios plus randomized sessions.
module tb_charge_bay_scheduler;
  import charge_pkg::*;

  localparam int NB = 4;
  localparam int TW = 12;

  logic            Clk = 1'b0;
  logic            nReset;
  logic            Tick;
  logic [NB-1:0]   Request;
  logic [4*NB-1:0] Mode;
  logic [TW*NB-1:0] ChargeTime;
  logic [NB-1:0]   Grant;
  logic            CounterEnable;
  logic [TW-1:0]   PresentTime;
  logic            Done;
  logic [2:0]      DoneBay;
  logic            Aborted;

  logic [3:0]    modeArr [NB];
  logic [TW-1:0] timeArr [NB];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      Mode[4*i +: 4]        = modeArr[i];
      ChargeTime[TW*i +: TW] = timeArr[i];
    end
  end

  charge_bay_scheduler #(.NUM_BAYS(NB), .TIME_W(TW)) dut (
    .Clk           (Clk),
    .nReset        (nReset),
    .Tick          (Tick),
    .Request       (Request),
    .Mode          (Mode),
    .ChargeTime    (ChargeTime),
    .Grant         (Grant),
    .CounterEnable (CounterEnable),
    .PresentTime   (PresentTime),
    .Done          (Done),
    .DoneBay       (DoneBay),
    .Aborted       (Aborted)
  );

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic pulse_tick();
    Tick = 1'b1;
    step();
    Tick = 1'b0;
  endtask

  task automatic clear_inputs();
    Tick    = 1'b0;
    Request = '0;
    for (int i = 0; i < NB; i++) begin
      modeArr[i] = 4'b0000;
      timeArr[i] = '0;
    end
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    step();
    nReset = 1'b1;
  endtask

  task automatic wait_grant(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      cycles++;
      if (Grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    nReset = 1'b0;
    step();
    step();
    checks++; if (Grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b exp 0000", Grant); end
    checks++; if (CounterEnable !== 1'b0) begin errors++; $display("FAIL rst_ce got %b exp 0", CounterEnable); end
    checks++; if (PresentTime !== 12'd0) begin errors++; $display("FAIL rst_time got %0d exp 0", PresentTime); end
    checks++; if ({Done, DoneBay, Aborted} !== 5'b0) begin errors++; $display("FAIL rst_done got %b exp 00000", {Done, DoneBay, Aborted}); end
    nReset = 1'b1;
    step();
    checks++; if (Grant !== 4'b0000) begin errors++; $display("FAIL rst_idle_grant got %b exp 0000", Grant); end
  endtask

  task automatic test_standard();
    clear_inputs();
    modeArr[1] = MODE_STD;
    timeArr[1] = 12'd3;
    Request    = 4'b0010;
    step();
    checks++; if (Grant !== 4'b0010) begin errors++; $display("FAIL std_grant got %b exp 0010", Grant); end
    checks++; if (CounterEnable !== 1'b1) begin errors++; $display("FAIL std_ce got %b exp 1", CounterEnable); end
    checks++; if (PresentTime !== 12'd3) begin errors++; $display("FAIL std_load got %0d exp 3", PresentTime); end
    step();
    checks++; if (PresentTime !== 12'd3) begin errors++; $display("FAIL std_hold got %0d exp 3", PresentTime); end
    for (int k = 1; k <= 3; k++) begin
      pulse_tick();
      checks++; if (PresentTime !== 12'(3 - k)) begin errors++; $display("FAIL std_tick%0d got %0d exp %0d", k, PresentTime, 3 - k); end
    end
    checks++; if (Done !== 1'b1 || DoneBay !== 3'd1 || Aborted !== 1'b0) begin errors++; $display("FAIL std_done got done=%b bay=%0d ab=%b exp 1 1 0", Done, DoneBay, Aborted); end
    checks++; if (CounterEnable !== 1'b0 || Grant !== 4'b0000) begin errors++; $display("FAIL std_release got ce=%b grant=%b exp 0 0000", CounterEnable, Grant); end
    Request = '0;
    step();
    checks++; if (Done !== 1'b0 || DoneBay !== 3'd1 || PresentTime !== 12'd0) begin errors++; $display("FAIL std_after got done=%b bay=%0d t=%0d exp 0 1 0", Done, DoneBay, PresentTime); end
  endtask

  task automatic test_fast();
    int expSeq [3] = '{3, 1, 0};
    clear_inputs();
    modeArr[2] = MODE_FAST;
    timeArr[2] = 12'd5;
    Request    = 4'b0100;
    step();
    checks++; if (Grant !== 4'b0100 || PresentTime !== 12'd5) begin errors++; $display("FAIL fast_grant got g=%b t=%0d exp 0100 5", Grant, PresentTime); end
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      checks++; if (PresentTime !== 12'(expSeq[k])) begin errors++; $display("FAIL fast_tick%0d got %0d exp %0d", k + 1, PresentTime, expSeq[k]); end
      checks++; if (Done !== (k == 2)) begin errors++; $display("FAIL fast_done%0d got %b exp %b", k + 1, Done, k == 2); end
    end
    Request = '0;
    step();
  endtask

  task automatic test_round_robin();
    int cycles;
    bit ok;
    clear_inputs();
    do_reset();
    for (int i = 0; i < NB; i++) begin
      modeArr[i] = (i % 2 == 0) ? MODE_STD : MODE_FAST;
      timeArr[i] = 12'd4;
    end
    Request = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant(cycles, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout session %0d got no grant exp grant", n); end
      checks++; if (cycles != ((n == 0) ? 1 : 2)) begin errors++; $display("FAIL rr_gap%0d got %0d exp %0d", n, cycles, (n == 0) ? 1 : 2); end
      checks++; if (Grant !== 4'(1 << (n % NB))) begin errors++; $display("FAIL rr_order%0d got %b exp %b", n, Grant, 4'(1 << (n % NB))); end
      while (Done !== 1'b1 && PresentTime != 0) pulse_tick();
      checks++; if (Done !== 1'b1 || DoneBay !== 3'(n % NB)) begin errors++; $display("FAIL rr_done%0d got done=%b bay=%0d exp 1 %0d", n, Done, DoneBay, n % NB); end
    end
    Request = '0;
    step();
  endtask

  task automatic test_invalid_mode();
    int cycles;
    bit ok;
    clear_inputs();
    modeArr[0] = 4'b0011;
    modeArr[3] = MODE_STD;
    timeArr[0] = 12'd1;
    timeArr[3] = 12'd1;
    Request    = 4'b1001;
    for (int n = 0; n < 3; n++) begin
      wait_grant(cycles, ok);
      checks++; if (!ok || Grant !== 4'b1000) begin errors++; $display("FAIL inv_grant%0d got %b exp 1000", n, Grant); end
      pulse_tick();
      checks++; if (Done !== 1'b1 || DoneBay !== 3'd3) begin errors++; $display("FAIL inv_done%0d got done=%b bay=%0d exp 1 3", n, Done, DoneBay); end
    end
    Request = '0;
    step();
    step();
  endtask

  task automatic test_abort();
    clear_inputs();
    modeArr[1] = MODE_STD;
    timeArr[1] = 12'd6;
    Request    = 4'b0010;
    step();
    checks++; if (Grant !== 4'b0010 || PresentTime !== 12'd6) begin errors++; $display("FAIL ab_grant got g=%b t=%0d exp 0010 6", Grant, PresentTime); end
    pulse_tick();
    checks++; if (PresentTime !== 12'd5) begin errors++; $display("FAIL ab_tick got %0d exp 5", PresentTime); end
    Tick    = 1'b1;
    Request = 4'b0000;
    step();
    Tick = 1'b0;
    checks++; if (Done !== 1'b1 || Aborted !== 1'b1 || DoneBay !== 3'd1) begin errors++; $display("FAIL ab_done got done=%b ab=%b bay=%0d exp 1 1 1", Done, Aborted, DoneBay); end
    checks++; if (PresentTime !== 12'd5 || CounterEnable !== 1'b0) begin errors++; $display("FAIL ab_freeze got t=%0d ce=%b exp 5 0", PresentTime, CounterEnable); end
    step();
    checks++; if (Done !== 1'b0 || Aborted !== 1'b1 || PresentTime !== 12'd5) begin errors++; $display("FAIL ab_hold got done=%b ab=%b t=%0d exp 0 1 5", Done, Aborted, PresentTime); end
  endtask

  task automatic test_mid_reset();
    clear_inputs();
    modeArr[0] = MODE_STD;
    timeArr[0] = 12'd7;
    modeArr[2] = MODE_STD;
    timeArr[2] = 12'd4;
    Request    = 4'b0001;
    step();
    checks++; if (Grant !== 4'b0001 || PresentTime !== 12'd7) begin errors++; $display("FAIL mr_grant got g=%b t=%0d exp 0001 7", Grant, PresentTime); end
    nReset = 1'b0;
    step();
    checks++; if ({Grant, CounterEnable, PresentTime, Done, DoneBay, Aborted} !== '0) begin errors++; $display("FAIL mr_zero got g=%b ce=%b t=%0d d=%b b=%0d a=%b exp all 0", Grant, CounterEnable, PresentTime, Done, DoneBay, Aborted); end
    nReset  = 1'b1;
    Request = 4'b0101;
    step();
    checks++; if (Grant !== 4'b0001 || PresentTime !== 12'd7) begin errors++; $display("FAIL mr_ptr got g=%b t=%0d exp 0001 7", Grant, PresentTime); end
    Request = '0;
    step();
    step();
  endtask

  // Session-level reference: round-robin pick from the eligibility rule, remaining time by arithmetic.
  task automatic test_random();
    int  ptr;
    int  bay;
    int  rem;
    int  abortCyc;
    bit  willAbort;
    bit  fast;
    bit  finished;
    bit  abortedExp;
    bit  elig [NB];
    bit  t;
    clear_inputs();
    do_reset();
    ptr = 0;
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < NB; i++) begin
        Request[i] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0, 2: modeArr[i] = MODE_STD;
          1:    modeArr[i] = MODE_FAST;
          default: begin
            modeArr[i] = 4'($urandom_range(0, 15));
            if (modeArr[i] == MODE_STD || modeArr[i] == MODE_FAST) modeArr[i] = 4'b1000;
          end
        endcase
        timeArr[i] = 12'($urandom_range(0, 9));
        elig[i]    = Request[i] && (modeArr[i] == MODE_STD || modeArr[i] == MODE_FAST);
      end
      if (!(elig[0] || elig[1] || elig[2] || elig[3])) begin
        bay          = int'($urandom_range(0, NB - 1));
        Request[bay] = 1'b1;
        modeArr[bay] = MODE_STD;
        elig[bay]    = 1'b1;
      end
      bay = -1;
      for (int k = 0; k < NB; k++) begin
        if (bay < 0 && elig[(ptr + k) % NB]) bay = (ptr + k) % NB;
      end
      rem  = int'(timeArr[bay]);
      fast = (modeArr[bay] == MODE_FAST);
      step();
      finished   = (rem == 0);
      abortedExp = 1'b0;
      if (!finished) begin
        checks++; if (Grant !== 4'(1 << bay) || PresentTime !== 12'(rem) || CounterEnable !== 1'b1) begin errors++; $display("FAIL rnd_grant s%0d got g=%b t=%0d ce=%b exp %b %0d 1", s, Grant, PresentTime, CounterEnable, 4'(1 << bay), rem); end
        modeArr[bay] = 4'($urandom_range(0, 15));
        timeArr[bay] = 12'($urandom_range(0, 4095));
        willAbort    = ($urandom_range(0, 3) == 0);
        abortCyc     = int'($urandom_range(0, 8));
        for (int c = 0; c < 60 && !finished; c++) begin
          t = (c >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
          Tick = t;
          if (willAbort && c == abortCyc) Request[bay] = 1'b0;
          step();
          Tick = 1'b0;
          if (willAbort && c == abortCyc) begin
            finished   = 1'b1;
            abortedExp = 1'b1;
          end else if (t) begin
            rem      = fast ? ((rem > 2) ? rem - 2 : 0) : rem - 1;
            finished = (rem == 0);
          end
          if (!finished) begin
            checks++; if (PresentTime !== 12'(rem) || Done !== 1'b0 || CounterEnable !== 1'b1) begin errors++; $display("FAIL rnd_run s%0d c%0d got t=%0d d=%b ce=%b exp %0d 0 1", s, c, PresentTime, Done, CounterEnable, rem); end
          end
        end
      end
      checks++; if (Done !== 1'b1 || DoneBay !== 3'(bay) || Aborted !== abortedExp) begin errors++; $display("FAIL rnd_done s%0d got d=%b bay=%0d ab=%b exp 1 %0d %b", s, Done, DoneBay, Aborted, bay, abortedExp); end
      checks++; if (PresentTime !== 12'(rem) || Grant !== 4'b0000 || CounterEnable !== 1'b0) begin errors++; $display("FAIL rnd_end s%0d got t=%0d g=%b ce=%b exp %0d 0000 0", s, PresentTime, Grant, CounterEnable, rem); end
      step();
      checks++; if (Done !== 1'b0 || DoneBay !== 3'(bay) || PresentTime !== 12'(rem)) begin errors++; $display("FAIL rnd_hold s%0d got d=%b bay=%0d t=%0d exp 0 %0d %0d", s, Done, DoneBay, PresentTime, bay, rem); end
      ptr = (bay + 1) % NB;
    end
    clear_inputs();
    step();
  endtask

  initial begin
    nReset = 1'b0;
    clear_inputs();
    test_reset();
    test_standard();
    test_fast();
    test_round_robin();
    test_invalid_mode();
    test_abort();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
